ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Programming controller for the configuration flip-flop (ccff) chain that threads through the io logical tiles.
- Accepts bitstream words over a valid/ready stream and serialises them onto ccff_head.
- Gates chain shifting with a clock enable and checks chain integrity with a marker bit read back from ccff_tail.
- Sits between the bitstream source (SoC-side loader) and the first tile's ccff_head; the last tile's ccff_tail returns here.

Parameters:
- WORD_W, 8: bitstream word width; bits shifted LSB first.
- CHAIN_LEN, 64: number of ccff bits in the chain. Must be a multiple of WORD_W; illegal values are an elaboration error.
- CNT_W, 16: width of the shift counter. Must hold CHAIN_LEN+1.

Ports:
- prog_clk, input, 1: programming clock; sole clock.
- pReset, input, 1: reset, asynchronous, active-low (0 = reset).
- start, input, 1: begin a programming session; sampled only in IDLE.
- abort, input, 1: terminate the session immediately.
- cfg_data, input, WORD_W: bitstream word.
- cfg_valid, input, 1: cfg_data valid.
- cfg_ready, output, 1: controller can accept a word.
- ccff_head, output, 1: serial data into the chain.
- ccff_tail, input, 1: serial data out of the chain's last flop.
- shift_en, output, 1: chain shift enable; the chain advances on a prog_clk rising edge when this is 1.
- busy, output, 1: session in progress.
- done, output, 1: one-cycle pulse at session end.
- error, output, 1: sticky failure flag.
- shift_cnt, output, CNT_W: number of completed shifts in the current session.

Behaviour:
- Reset (pReset=0, at any time including mid-session): state IDLE; all outputs 0; word and bit registers 0. No partial shift occurs.
- All outputs are registered.
- States: IDLE, MARK, WAIT, SHIFT, DONE.
- IDLE:
  - cfg_ready=0; cfg_valid ignored.
  - start=1 -> MARK; clear error and shift_cnt; busy=1 from the next cycle.
- MARK:
  - Exactly 1 cycle with shift_en=1 and ccff_head=1 (marker bit); shift_cnt increments to 1.
  - Then -> WAIT.
- WAIT:
  - cfg_ready=1, shift_en=0; the chain holds.
  - On cfg_valid & cfg_ready, capture cfg_data, set bit index to 0, and go to SHIFT.
  - Source stalls of any length are legal.
- SHIFT:
  - WORD_W consecutive cycles with shift_en=1, cfg_ready=0.
  - ccff_head = word[bit index], bit 0 first.
  - shift_cnt increments by 1 each cycle.
  - After bit WORD_W-1:
    - if shift_cnt has reached CHAIN_LEN+1 -> DONE;
    - else -> WAIT.
  - No back-to-back acceptance inside SHIFT: at least 1 WAIT cycle separates words.
- Integrity check:
  - In the shift cycle where shift_cnt==CHAIN_LEN before incrementing (the final shift), ccff_tail must be 1; it holds the marker at that point.
  - If ccff_tail is 0, set error.
  - The final shift pushes the marker out, so the chain holds exactly the CHAIN_LEN data bits. The first data bit shifted ends at the tail end of the chain.
- DONE:
  - done=1 for 1 cycle, busy=0 from the same cycle; error reflects the check.
  - Then -> IDLE. shift_cnt holds its final value until the next start.
- Session length:
  - Total shifts = CHAIN_LEN+1.
  - Words consumed = CHAIN_LEN/WORD_W.
  - Minimum session = 1 + (CHAIN_LEN/WORD_W)*(WORD_W+1) cycles after MARK entry.
- abort:
  - Honoured in MARK, WAIT or SHIFT with priority over all other events.
  - Next cycle: IDLE, shift_en=0, cfg_ready=0, busy=0, error=1, done=0.
  - A word accepted on the same cycle as abort is discarded.
  - abort in IDLE/DONE has no effect.
- start while busy: ignored. start in the DONE cycle: ignored; a new start must be presented in IDLE.
- error remains set until the next accepted start.
- shift_cnt saturates at CHAIN_LEN+1; it never wraps.

Test Plan:
- Setup: CHAIN_LEN=16, WORD_W=8, behavioural 16-flop chain model clocked by prog_clk and enabled by shift_en.
- Nominal load: start, then words 0xA5 and 0x3C with no stalls -> 17 shift_en cycles; done pulse; error=0; shift_cnt=17; chain[tail..head] = bits of 0xA5 LSB-first then 0x3C LSB-first.
- Source stalls: same words with cfg_valid low for 5 cycles before and between words -> identical final chain contents; shift_en=0 throughout stalls; cfg_ready=1 only in WAIT.
- Wrong chain length: model a 15-flop chain -> ccff_tail=0 at final-shift sample; done pulse with error=1.
- Abort mid-word: abort at the 3rd SHIFT cycle of word 2 -> next cycle busy=0, shift_en=0, error=1, no done pulse; a subsequent start clears error and a full reload passes.
- Reset mid-session: pReset=0 asynchronously during SHIFT -> all outputs 0 immediately and the FSM is in IDLE after release; start with cfg_valid held high is ignored until start arrives, and then loads correctly.
- Ignored inputs: start pulsed during SHIFT and cfg_valid=1 in IDLE -> no state change, no extra shifts, shift_cnt unchanged.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// ============================================================================
// Module   : ccff_chain_loader_if
// Brief    : Bitstream word stream (valid/ready) from the SoC-side loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// Module   : ccff_chain_loader
// Brief    : Serialises bitstream words onto the ccff chain with a marker-bit
//            integrity check read back from ccff_tail.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  input  logic                 abort,
  ccff_chain_loader_if.slave   cfg,
  output logic                 ccff_head,
  input  logic                 ccff_tail,
  output logic                 shift_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     shift_cnt
);

  localparam int               BIT_W       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] c_FINAL_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] c_TOTAL_CNT = CNT_W'(CHAIN_LEN + 1);
  localparam logic [BIT_W-1:0] c_LAST_BIT  = BIT_W'(WORD_W - 1);

  if (((CHAIN_LEN % WORD_W) != 0) || (CHAIN_LEN < WORD_W)) begin : g_bad_chain_len
    $error("ccff_chain_loader: CHAIN_LEN must be a non-zero multiple of WORD_W");
  end
  if (((CHAIN_LEN + 1) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("ccff_chain_loader: CNT_W too narrow to hold CHAIN_LEN+1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [WORD_W-1:0] r_word,      w_word_nxt;
  logic [BIT_W-1:0]  r_bit,       w_bit_nxt;
  logic [BIT_W-1:0]  w_bit_inc;
  logic [CNT_W-1:0]  r_shift_cnt, w_cnt_nxt;
  logic              r_cfg_ready, w_cfg_ready_nxt;
  logic              r_shift_en,  w_shift_en_nxt;
  logic              r_head,      w_head_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_error,     w_error_nxt;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_bit       <= '0;
      r_shift_cnt <= '0;
      r_cfg_ready <= 1'b0;
      r_shift_en  <= 1'b0;
      r_head      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word      <= w_word_nxt;
      r_bit       <= w_bit_nxt;
      r_shift_cnt <= w_cnt_nxt;
      r_cfg_ready <= w_cfg_ready_nxt;
      r_shift_en  <= w_shift_en_nxt;
      r_head      <= w_head_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  // Outputs are computed for the state being entered, so each registered
  // output is valid for the whole cycle spent in that state.
  always_comb begin
    w_state_nxt     = r_state;
    w_word_nxt      = r_word;
    w_bit_nxt       = r_bit;
    w_bit_inc       = r_bit + 1'b1;
    w_cnt_nxt       = r_shift_cnt;
    w_cfg_ready_nxt = 1'b0;
    w_shift_en_nxt  = 1'b0;
    w_head_nxt      = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_error_nxt     = r_error;

    if (r_shift_en && (r_shift_cnt != c_TOTAL_CNT)) begin
      w_cnt_nxt = r_shift_cnt + 1'b1;
    end
    // On the final shift the marker must be sitting in the last flop.
    if (r_shift_en && (r_shift_cnt == c_FINAL_CNT) && !ccff_tail) begin
      w_error_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_MARK;
          w_error_nxt    = 1'b0;
          w_cnt_nxt      = '0;
          w_busy_nxt     = 1'b1;
          w_shift_en_nxt = 1'b1;
          w_head_nxt     = 1'b1;
        end
      end
      S_MARK: begin
        w_state_nxt     = S_WAIT;
        w_busy_nxt      = 1'b1;
        w_cfg_ready_nxt = 1'b1;
      end
      S_WAIT: begin
        w_busy_nxt = 1'b1;
        if (cfg.cfg_valid && r_cfg_ready) begin
          w_state_nxt    = S_SHIFT;
          w_word_nxt     = cfg.cfg_data;
          w_bit_nxt      = '0;
          w_shift_en_nxt = 1'b1;
          w_head_nxt     = cfg.cfg_data[0];
        end else begin
          w_cfg_ready_nxt = 1'b1;
        end
      end
      S_SHIFT: begin
        w_busy_nxt = 1'b1;
        if (r_bit == c_LAST_BIT) begin
          if (w_cnt_nxt == c_TOTAL_CNT) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt     = S_WAIT;
            w_cfg_ready_nxt = 1'b1;
          end
        end else begin
          w_bit_nxt      = w_bit_inc;
          w_shift_en_nxt = 1'b1;
          w_head_nxt     = r_word[w_bit_inc];
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort outranks everything, including a word accepted this same cycle.
    if (abort && ((r_state == S_MARK) || (r_state == S_WAIT) || (r_state == S_SHIFT))) begin
      w_state_nxt     = S_IDLE;
      w_word_nxt      = r_word;
      w_bit_nxt       = r_bit;
      w_cfg_ready_nxt = 1'b0;
      w_shift_en_nxt  = 1'b0;
      w_head_nxt      = 1'b0;
      w_busy_nxt      = 1'b0;
      w_done_nxt      = 1'b0;
      w_error_nxt     = 1'b1;
    end
  end

  assign cfg.cfg_ready = r_cfg_ready;
  assign ccff_head     = r_head;
  assign shift_en      = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign shift_cnt     = r_shift_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// ============================================================================
// Module   : tb_ccff_chain_loader
// Brief    : Directed bench for ccff_chain_loader with a 16/15-flop chain model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ccff_chain_loader;

  logic        prog_clk = 1'b0;
  logic        pReset   = 1'b0;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic        ccff_head, ccff_tail, shift_en, busy, done, error;
  logic [15:0] shift_cnt;

  logic [15:0] chain       = 16'h0000;
  logic        short_chain = 1'b0;

  int checks   = 0;
  int failures = 0;
  int n_shift  = 0;
  int n_done   = 0;
  int n_overlap = 0;

  ccff_chain_loader_if #(.WORD_W(8)) cfg_if ();

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(16), .CNT_W(16)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start),
    .abort     (abort),
    .cfg       (cfg_if.slave),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .shift_cnt (shift_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  // chain[0] is the head end; the tail is flop 15 (or 14 for the short chain)
  assign ccff_tail = short_chain ? chain[14] : chain[15];
  always @(posedge prog_clk) if (shift_en === 1'b1) chain <= {chain[14:0], ccff_head};

  always @(posedge prog_clk) begin
    if (shift_en === 1'b1) n_shift++;
    if (done === 1'b1) n_done++;
    if ((shift_en === 1'b1) && (cfg_if.cfg_ready === 1'b1)) n_overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, output bit ok);
    ok = 1'b0;
    cfg_if.cfg_data  = w;
    cfg_if.cfg_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cfg_if.cfg_ready === 1'b1) begin
        tick;
        ok = 1'b1;
        break;
      end
      tick;
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    cfg_if.cfg_data  = 8'h00;
    cfg_if.cfg_valid = 1'b0;
    #3;
    checks++; if (busy !== 1'b0)            begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (shift_en !== 1'b0)        begin failures++; $display("FAIL rst_shift_en got=%b exp=0", shift_en); end
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_cfg_ready got=%b exp=0", cfg_if.cfg_ready); end
    checks++; if ({done, error, ccff_head} !== 3'b000) begin failures++; $display("FAIL rst_done_err_head got=%b exp=000", {done, error, ccff_head}); end
    checks++; if (shift_cnt !== 16'd0)      begin failures++; $display("FAIL rst_shift_cnt got=%0d exp=0", shift_cnt); end
    #4 pReset = 1'b1;
    tick;
    tick;
  endtask

  task automatic test_nominal;
    bit a0, a1, seen;
    int s0;
    s0 = n_shift;
    do_start;
    checks++; if ({busy, shift_en, ccff_head, cfg_if.cfg_ready} !== 4'b1110) begin failures++; $display("FAIL nom_mark busy/sh/head/rdy got=%b exp=1110", {busy, shift_en, ccff_head, cfg_if.cfg_ready}); end
    send_word(8'hA5, a0);
    send_word(8'h3C, a1);
    checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL nom_accept got=%b exp=11", {a0, a1}); end
    wait_done(seen);
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL nom_done_timeout got=%b exp=1", seen); end
    checks++; if ({busy, error} !== 2'b00) begin failures++; $display("FAIL nom_done_busy_err got=%b exp=00", {busy, error}); end
    checks++; if (shift_cnt !== 16'd17) begin failures++; $display("FAIL nom_shift_cnt got=%0d exp=17", shift_cnt); end
    checks++; if (n_shift - s0 != 17) begin failures++; $display("FAIL nom_shift_cycles got=%0d exp=17", n_shift - s0); end
    checks++; if (chain !== 16'hA53C) begin failures++; $display("FAIL nom_chain got=%h exp=a53c", chain); end
    tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL nom_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_stalls;
    bit a0, a1, seen;
    int bad;
    bad = 0;
    do_start;
    tick;
    for (int i = 0; i < 5; i++) begin
      if ((cfg_if.cfg_ready !== 1'b1) || (shift_en !== 1'b0)) bad++;
      tick;
    end
    send_word(8'hA5, a0);
    for (int i = 0; i < 12; i++) begin
      if (cfg_if.cfg_ready === 1'b1) break;
      if (shift_en !== 1'b1) bad++;
      tick;
    end
    for (int i = 0; i < 5; i++) begin
      if ((cfg_if.cfg_ready !== 1'b1) || (shift_en !== 1'b0)) bad++;
      tick;
    end
    send_word(8'h3C, a1);
    wait_done(seen);
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_cycles bad=%0d exp=0", bad); end
    checks++; if ({a0, a1, seen, error} !== 4'b1110) begin failures++; $display("FAIL stall_acc_done_err got=%b exp=1110", {a0, a1, seen, error}); end
    checks++; if (chain !== 16'hA53C) begin failures++; $display("FAIL stall_chain got=%h exp=a53c", chain); end
    checks++; if (n_overlap != 0) begin failures++; $display("FAIL ready_during_shift count=%0d exp=0", n_overlap); end
    tick;
  endtask

  // 0xA4 puts a 0 in the tail of the 15-flop chain at the final-shift sample
  task automatic test_wrong_length;
    bit a0, a1, seen;
    short_chain = 1'b1;
    do_start;
    send_word(8'hA4, a0);
    send_word(8'h3C, a1);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL short_err_before_final got=%b exp=0", error); end
    wait_done(seen);
    checks++; if ({a0, a1, seen} !== 3'b111) begin failures++; $display("FAIL short_acc_done got=%b exp=111", {a0, a1, seen}); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL short_error got=%b exp=1", error); end
    short_chain = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    bit a0, a1, seen;
    int d0;
    d0 = n_done;
    do_start;
    send_word(8'hA5, a0);
    send_word(8'h3C, a1);
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if ({busy, shift_en, cfg_if.cfg_ready, done} !== 4'b0000) begin failures++; $display("FAIL abort_outputs busy/sh/rdy/done got=%b exp=0000", {busy, shift_en, cfg_if.cfg_ready, done}); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL abort_error got=%b exp=1", error); end
    repeat (4) tick;
    checks++; if (n_done != d0) begin failures++; $display("FAIL abort_no_done got=%0d exp=%0d", n_done, d0); end
    do_start;
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL abort_restart_clear got=%b exp=0", error); end
    send_word(8'h12, a0);
    send_word(8'hC8, a1);
    wait_done(seen);
    checks++; if ({seen, error} !== 2'b10) begin failures++; $display("FAIL abort_reload_done_err got=%b exp=10", {seen, error}); end
    checks++; if (chain !== 16'h4813) begin failures++; $display("FAIL abort_reload_chain got=%h exp=4813", chain); end
    tick;
  endtask

  task automatic test_reset_mid;
    bit a0, a1, seen;
    int bad, s0;
    bad = 0;
    do_start;
    send_word(8'hA5, a0);
    tick;
    #3 pReset = 1'b0;
    #1;
    checks++; if ({busy, shift_en, cfg_if.cfg_ready, done, error, ccff_head} !== 6'b0) begin failures++; $display("FAIL rstmid_outputs got=%b exp=000000", {busy, shift_en, cfg_if.cfg_ready, done, error, ccff_head}); end
    checks++; if (shift_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_shift_cnt got=%0d exp=0", shift_cnt); end
    #2 pReset = 1'b1;
    s0 = n_shift;
    cfg_if.cfg_data  = 8'h77;
    cfg_if.cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if ({busy, shift_en, cfg_if.cfg_ready} !== 3'b000) bad++;
    end
    checks++; if ((bad != 0) || (n_shift != s0)) begin failures++; $display("FAIL rstmid_idle_valid bad=%0d shifts=%0d exp=0", bad, n_shift - s0); end
    do_start;
    send_word(8'h12, a0);
    send_word(8'hC8, a1);
    wait_done(seen);
    checks++; if ({seen, error} !== 2'b10) begin failures++; $display("FAIL rstmid_reload_done_err got=%b exp=10", {seen, error}); end
    checks++; if ((chain !== 16'h4813) || (shift_cnt !== 16'd17)) begin failures++; $display("FAIL rstmid_reload chain=%h cnt=%0d exp=4813/17", chain, shift_cnt); end
    tick;
  endtask

  task automatic test_ignored_inputs;
    bit a0, a1, seen;
    int bad, s0, s1;
    bad = 0;
    s0 = n_shift;
    do_start;
    send_word(8'hA5, a0);
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++; if ({busy, shift_en} !== 2'b11 || shift_cnt !== 16'd3) begin failures++; $display("FAIL ign_start_shift busy/sh=%b cnt=%0d exp=11/3", {busy, shift_en}, shift_cnt); end
    send_word(8'h3C, a1);
    wait_done(seen);
    checks++; if ((n_shift - s0 != 17) || (chain !== 16'hA53C)) begin failures++; $display("FAIL ign_session shifts=%0d chain=%h exp=17/a53c", n_shift - s0, chain); end
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++; if ({busy, shift_en} !== 2'b00) begin failures++; $display("FAIL ign_start_in_done got=%b exp=00", {busy, shift_en}); end
    s1 = n_shift;
    cfg_if.cfg_data  = 8'hFF;
    cfg_if.cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if ({busy, shift_en, cfg_if.cfg_ready} !== 3'b000) bad++;
    end
    cfg_if.cfg_valid = 1'b0;
    checks++; if ((bad != 0) || (n_shift != s1)) begin failures++; $display("FAIL ign_valid_idle bad=%0d shifts=%0d exp=0", bad, n_shift - s1); end
    checks++; if (shift_cnt !== 16'd17) begin failures++; $display("FAIL ign_cnt_hold got=%0d exp=17", shift_cnt); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_stalls;
    test_wrong_length;
    test_abort;
    test_reset_mid;
    test_ignored_inputs;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
